msg_block_packer: RTL and testbench

- Writer-side counterpart to the message word splitter.
- Accepts a serial stream of 32-bit message words over a valid/ready handshake and packs them big-endian into one SHA-256 message block. Word 0 occupies the most significant bits.
- Presents the completed block with its own valid/ready handshake to the hashing/compression path.
- Supports early termination (in_last), with zero fill of the unused words.

---
 rtl/msg_block_packer_if.sv | 26 ++
 rtl/msg_block_packer.sv | 94 +++++++++
 tb/tb_msg_block_packer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/msg_block_packer_if.sv
// Handshake bundle between a word producer, the block packer and the block consumer.
// master: environment side (drives words in, takes blocks out); slave: the packer.
// Signals: in_valid/in_data/in_last/in_ready (word stream), out_valid/out_block/out_count/out_ready (block).
interface msg_block_packer_if #(
  parameter int WORDS = 16,
  parameter int CNT_W = 5
);
  logic                  in_valid;
  logic [31:0]           in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [WORDS*32-1:0]   out_block;
  logic [CNT_W-1:0]      out_count;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_block, out_count
  );
endinterface

// File: rtl/msg_block_packer.sv
// Purpose: packs 32-bit message words big-endian (word 0 in the MSBs) into one SHA-256 block, zero-filling after in_last.
// Latency: out_valid rises on the edge that accepts the final word; a full block takes WORDS+1 cycles including handoff.
// Backpressure: while a block is held, in_ready=0 and the block stays stable until out_ready; no same-cycle refill.
//
// Ports: clk, rst (async active-high), bus (msg_block_packer_if.slave):
//   in_valid/in_data/in_last/in_ready - word stream in; out_valid/out_block/out_count/out_ready - block out.
// Build option: define MSG_BYTE_SWAP_EN to byte-reverse each accepted word before storage
//   (raw little-endian header fields). Handshake and timing are unchanged.
module msg_block_packer #(
  parameter int WORDS = 16,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst,
  msg_block_packer_if.slave bus
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  state_t              state;
  logic [CNT_W-1:0]    idx;
  logic [WORDS*32-1:0] blk;
  logic [CNT_W-1:0]    cnt;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [31:0]         word;

`ifdef MSG_BYTE_SWAP_EN
  assign word = {bus.in_data[7:0], bus.in_data[15:8], bus.in_data[23:16], bus.in_data[31:24]};
`else
  assign word = bus.in_data;
`endif

  // in_ready/out_valid are registered copies of the state decode, so neither
  // depends combinationally on in_valid or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      idx         <= '0;
      blk         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            for (int k = 0; k < WORDS; k++) begin
              if (idx == CNT_W'(k)) begin
                blk[(WORDS-k)*32-1 -: 32] <= word;
              end
            end
            if (idx == LAST_IDX || bus.in_last) begin
              // idx is left alone; it is cleared on handoff
              state       <= HOLD;
              cnt         <= idx + 1'b1;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // clearing here is what provides the zero fill of the next short block
            state       <= FILL;
            idx         <= '0;
            blk         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = blk;
  assign bus.out_count = cnt;

endmodule

// File: tb/tb_msg_block_packer.sv
module tb_msg_block_packer;

  localparam int WORDS = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic [511:0] blk;
    logic [4:0]   cnt;
  } exp_t;

  logic clk;
  logic rst;

  msg_block_packer_if #(.WORDS(WORDS), .CNT_W(CNT_W)) bus ();

  msg_block_packer #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  // bench-side model of the block under construction
  logic [511:0] cur_blk;
  int           cur_slot;
  logic         prev_ov;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef MSG_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Offer one word and wait (bounded) for it to be accepted; keep=1 leaves in_valid high.
  task automatic send_word(input logic [31:0] d, input logic last, input logic keep);
    bit ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!keep) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: word %h not accepted within 50 cycles", d);
    end else begin
      cur_blk[(WORDS-cur_slot)*32-1 -: 32] = stored(d);
      cur_slot++;
      if (last || cur_slot == WORDS) begin
        e.blk = cur_blk;
        e.cnt = 5'(cur_slot);
        sb.push_back(e);
        cur_blk  = '0;
        cur_slot = 0;
      end
    end
  endtask

  task automatic handoff(input string name);
    int t;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({name, "_ov_after"}, 512'(bus.out_valid), 512'(0));
    chk({name, "_ir_after"}, 512'(bus.in_ready), 512'(1));
    chk({name, "_blk_after"}, bus.out_block, 512'(0));
    chk({name, "_cnt_after"}, 512'(bus.out_count), 512'(0));
  endtask

  // Scoreboard monitor: compares each newly presented block with the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: block %h count %0d with no expectation", bus.out_block, bus.out_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_block", bus.out_block, e.blk);
          chk("sb_count", 512'(bus.out_count), 512'(e.cnt));
          chk("sb_in_ready_low", 512'(bus.in_ready), 512'(0));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  logic [511:0] full_exp;

  initial begin
    cur_blk       = '0;
    cur_slot      = 0;
    prev_ov       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_out_block", bus.out_block, 512'(0));
    chk("rst_out_count", 512'(bus.out_count), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // full block, back to back, consumer not ready
    for (int i = 1; i <= 16; i++) send_word(32'(i), 1'b0, i != 16);
    chk("full_ov_next_cycle", 512'(bus.out_valid), 512'(1));
    chk("full_in_ready", 512'(bus.in_ready), 512'(0));
    chk("full_word0", 512'(bus.out_block[511:480]), 512'(32'h0000_0001));
    chk("full_word15", 512'(bus.out_block[31:0]), 512'(32'h0000_0010));
    chk("full_count", 512'(bus.out_count), 512'(16));
    full_exp = '0;
    for (int i = 0; i < 16; i++) full_exp[(16-i)*32-1 -: 32] = 32'(i + 1);

    // backpressure: held block ignores input
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 512'(bus.in_ready), 512'(0));
      chk("bp_block_stable", bus.out_block, full_exp);
    end
    handoff("bp");   // in_valid still high over the handoff edge: must not refill that cycle
    bus.in_valid = 1'b0;

    // early last
    send_word(32'hAAAA_0000, 1'b0, 1'b1);
    send_word(32'hBBBB_0000, 1'b0, 1'b1);
    send_word(32'hCCCC_0000, 1'b1, 1'b0);
    chk("early_count", 512'(bus.out_count), 512'(3));
    chk("early_w0", 512'(bus.out_block[511:480]), 512'(32'hAAAA_0000));
    chk("early_w2", 512'(bus.out_block[447:416]), 512'(32'hCCCC_0000));
    chk("early_zero_fill", 512'(bus.out_block[415:0]), 512'(0));
    handoff("early");

    // gapped input
    for (int i = 1; i <= 16; i++) begin
      send_word(32'(i), 1'b0, 1'b0);
      if (i == 15) chk("gap_no_ov_before_last", 512'(bus.out_valid), 512'(0));
      if (i != 16) repeat (2) @(posedge clk);
      if (i != 16) #1;
    end
    chk("gap_block", bus.out_block, full_exp);
    handoff("gap");

    // reset mid-fill discards the partial block
    for (int i = 0; i < 5; i++) send_word(32'h100 + 32'(i), 1'b0, 1'b0);
    rst = 1'b1;
    cur_blk  = '0;
    cur_slot = 0;
    #2;
    chk("midrst_block", bus.out_block, 512'(0));
    chk("midrst_count", 512'(bus.out_count), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) send_word(32'h10 + 32'(i), 1'b0, i != 15);
    chk("midrst_w0", 512'(bus.out_block[511:480]), 512'(32'h0000_0010));
    chk("midrst_w15", 512'(bus.out_block[31:0]), 512'(32'h0000_001F));
    chk("midrst_count16", 512'(bus.out_count), 512'(16));
    handoff("midrst");

    // single word with last; byte order depends on the build
    send_word(32'h0100_0000, 1'b1, 1'b0);
`ifdef MSG_BYTE_SWAP_EN
    chk("swap_w0", 512'(bus.out_block[511:480]), 512'(32'h0000_0001));
`else
    chk("swap_w0", 512'(bus.out_block[511:480]), 512'(32'h0100_0000));
`endif
    chk("swap_count", 512'(bus.out_count), 512'(1));
    handoff("swap");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 512'(sb.size()), 512'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
